risc_pipe_fetch: RTL
====================

Name: risc_pipe_fetch

Overview:
- Parametrised instruction-fetch front end for the RISC pipeline.
- Owns the fetch PC and issues in-order requests to instruction memory.
- Buffers responses in a DEPTH-entry prefetch queue and hands {pc, instr} to decode over a valid/ready handshake.
- Supports branch/jump redirect, which flushes the queue and discards stale in-flight responses.

Parameters:
- XLEN, 32, PC/address width.
- ILEN, 32, instruction width.
- DEPTH, 4, prefetch queue entries; power of 2, ≥2.
- RESET_PC, 0, PC loaded on reset.
- PC_STEP, 4, PC increment per accepted request.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- fetch_en  in  1  permits new requests
- imem_req_valid  out  1  request valid
- imem_req_addr  out  XLEN  request address (current PC)
- imem_req_ready  in  1  memory accepts request
- imem_rsp_valid  in  1  response valid; in order; arrives ≥1 cycle after accept
- imem_rsp_data  in  ILEN  instruction word
- redirect_valid  in  1  redirect/flush pulse
- redirect_pc  in  XLEN  new fetch PC
- if_valid  out  1  head entry valid to decode
- if_ready  in  1  decode accepts head
- if_pc  out  XLEN  PC of head instruction
- if_instr  out  ILEN  head instruction

Behaviour:
- Clocking: single clock clk; rst is synchronous and active-high.
- Reset values: pc=RESET_PC; queue empty; alloc=0; drop_cnt=0; imem_req_valid=0; if_valid=0; if_pc=0; if_instr=0.
- Queue slot lifecycle:
  - A slot is allocated on request accept (imem_req_valid & imem_req_ready) and stores the PC.
  - It is filled by the next non-dropped response.
  - It pops on if_valid & if_ready.
- Request issue:
  - imem_req_valid = fetch_en & !redirect_valid & !rst & (alloc + drop_cnt < DEPTH).
  - Address = pc. On accept, pc <= pc + PC_STEP, modulo 2^XLEN (wraps silently).
- Response handling:
  - If drop_cnt>0, the response is discarded and drop_cnt decrements.
  - Otherwise it fills the oldest unfilled slot.
  - A response with no unfilled slot and drop_cnt=0 is a protocol error; it is ignored and flagged by a simulation assertion.
- Output to decode:
  - if_valid=1 iff the head slot is allocated and filled. Registered: data is visible the cycle after the response.
  - if_pc/if_instr hold stable while if_valid & !if_ready.
- Redirect (highest priority):
  - All slots are freed and if_valid drops next cycle.
  - pc <= redirect_pc.
  - drop_cnt <= drop_cnt + (allocated-unfilled slots) − (1 if a response arrives that cycle and is counted against them).
  - No request is issued in the redirect cycle.
  - A pop in the redirect cycle is honoured as a handshake, but the queue is emptied regardless.
- Simultaneous events:
  - Push and pop in the same cycle are both performed.
  - Fill and pop of different slots in the same cycle are both performed.
  - Full (alloc=DEPTH): no request. Empty: if_valid=0.
- Reset mid-operation: state returns to reset values and drop_cnt clears. The memory is also reset by the same rst, so no stale responses occur.
- Counter widths: alloc and drop_cnt are $clog2(DEPTH)+1 bits; pointers are $clog2(DEPTH) bits and wrap naturally.

Optional Feature:
- Macro: RISC_FETCH_BYPASS_EN.
- Defined:
  - When the queue holds no filled slot and a non-dropped response fills the head slot, if_valid/if_instr/if_pc present it combinationally in the same cycle.
  - If if_ready=1, that entry is consumed without being marked filled, giving 0-cycle response-to-decode latency.
- Undefined: the response is always registered first (1-cycle latency). No ports change.

Decomposition:
- Package risc_pipe_pkg:
  - XLEN/ILEN defaults.
  - Fetch-entry typedef {pc, instr, filled}.
  - RESET_PC default.
  - PC_STEP.
- One natural sub-module, risc_pipe_fetch_q: a DEPTH-entry queue with separate alloc, fill and pop pointers, plus a flush input.

Test Plan:
- Steady stream: fetch_en=1, ready always 1, 1-cycle memory → PCs 0,4,8,12… appear on if_pc in order, one per cycle after a 2-cycle fill (1 cycle with bypass).
- Backpressure: if_ready=0, DEPTH=4 → exactly 4 requests (0..12), then imem_req_valid=0. if_pc=0 is held stable. Releasing if_ready resumes at 16.
- Redirect with in-flight requests: 3 requests (0,4,8) outstanding and unanswered, redirect_pc=0x100 → 3 responses dropped; the next if_pc is 0x100, followed by 0x104.
- Redirect in the same cycle as a response, with 2 outstanding → drop_cnt=1; only the following response is discarded.
- PC wrap: RESET_PC=0xFFFFFFF8 → requests 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
- Reset mid-stream with a full queue → next cycle if_valid=0, imem_req_valid=0, pc=RESET_PC; fetching restarts cleanly.

Source files
------------

// File: rtl/risc_pipe_pkg.sv
// Shared types and defaults for the RISC pipeline fetch front end.
package risc_pipe_pkg;

  localparam int XLEN_DEF = 32;
  localparam int ILEN_DEF = 32;

  localparam logic [XLEN_DEF-1:0] RESET_PC_DEF = '0;
  localparam logic [XLEN_DEF-1:0] PC_STEP_DEF  = 32'd4;

  // One prefetch slot as seen by decode: fetch address, instruction word and
  // whether the memory response has landed yet.
  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [ILEN_DEF-1:0] instr;
    logic                filled;
  } fetch_entry_t;

endpackage

// File: rtl/risc_pipe_fetch_q.sv
// Prefetch queue: slots are allocated in request order, filled in response
// order and popped in order, so three pointers walk the same ring.
// With RISC_FETCH_BYPASS_EN defined, a response landing on an empty-of-filled
// head slot is presented to decode in the same cycle and may be consumed
// without ever being marked filled.
module risc_pipe_fetch_q #(
  parameter int XLEN  = 32,
  parameter int ILEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    alloc_en,
  input  logic [XLEN-1:0]         alloc_pc,
  input  logic                    fill_en,
  input  logic [ILEN-1:0]         fill_data,
  input  logic                    pop_en,
  output logic [$clog2(DEPTH):0]  alloc_cnt,
  output logic [$clog2(DEPTH):0]  unfilled_cnt,
  output logic                    head_valid,
  output logic [XLEN-1:0]         head_pc,
  output logic [ILEN-1:0]         head_instr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [ILEN-1:0] instr_mem [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr, fill_ptr;
  logic [CW-1:0]   filled_cnt;
  logic            bypass;
  logic            bypass_pop;

`ifdef RISC_FETCH_BYPASS_EN
  // No filled slot means fill_ptr == rd_ptr, so this fill targets the head.
  assign bypass = fill_en & (filled_cnt == '0);
`else
  assign bypass = 1'b0;
`endif

  assign bypass_pop   = bypass & pop_en;
  assign unfilled_cnt = alloc_cnt - filled_cnt;
  assign head_valid   = (filled_cnt != '0) | bypass;
  assign head_pc      = pc_mem[rd_ptr];
  assign head_instr   = bypass ? fill_data : instr_mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush drops every slot at once.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fill_ptr   <= '0;
      alloc_cnt  <= '0;
      filled_cnt <= '0;
    end else begin
      if (alloc_en) wr_ptr   <= wr_ptr + PW'(1);
      if (fill_en)  fill_ptr <= fill_ptr + PW'(1);
      if (pop_en)   rd_ptr   <= rd_ptr + PW'(1);
      alloc_cnt  <= alloc_cnt + CW'(alloc_en) - CW'(pop_en);
      filled_cnt <= filled_cnt + CW'(fill_en & ~bypass_pop)
                               - CW'(pop_en & ~bypass_pop);
    end
  end

  // Slot payload storage; only valid slots are ever read out, so no reset.
  always_ff @(posedge clk) begin
    if (alloc_en) pc_mem[wr_ptr]      <= alloc_pc;
    if (fill_en)  instr_mem[fill_ptr] <= fill_data;
  end

endmodule

// File: rtl/risc_pipe_fetch.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order requests,
// buffers responses in the prefetch queue and hands {pc, instr} to decode.
// Redirect flushes the queue; responses for requests already in flight are
// counted in drop_cnt and discarded as they return.
// Optional: RISC_FETCH_BYPASS_EN enables same-cycle response-to-decode bypass.
module risc_pipe_fetch
  import risc_pipe_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter int              ILEN     = ILEN_DEF,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
  parameter logic [XLEN-1:0] PC_STEP  = XLEN'(PC_STEP_DEF)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_en,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [ILEN-1:0] if_instr
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] pc;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   alloc_cnt;
  logic [CW-1:0]   unfilled_cnt;
  logic [CW-1:0]   outstanding;
  logic [CW:0]     inflight;
  logic            req_accept;
  logic            fill_en;
  logic            pop_en;
  logic            head_valid;
  logic [XLEN-1:0] head_pc;
  logic [ILEN-1:0] head_instr;

  // Every slot plus every doomed response still owes the memory a reply, so
  // both count against queue capacity.
  assign inflight       = {1'b0, alloc_cnt} + {1'b0, drop_cnt};
  assign outstanding    = drop_cnt + unfilled_cnt;
  assign imem_req_valid = fetch_en & ~redirect_valid & ~rst
                          & (inflight < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc;
  assign req_accept     = imem_req_valid & imem_req_ready;
  assign fill_en        = imem_rsp_valid & ~redirect_valid
                          & (drop_cnt == '0) & (unfilled_cnt != '0);
  assign pop_en         = if_valid & if_ready;

  assign if_valid = head_valid;
  assign if_pc    = head_valid ? head_pc    : '0;
  assign if_instr = head_valid ? head_instr : '0;

  risc_pipe_fetch_q #(
    .XLEN  (XLEN),
    .ILEN  (ILEN),
    .DEPTH (DEPTH)
  ) u_q (
    .clk          (clk),
    .rst          (rst),
    .flush        (redirect_valid),
    .alloc_en     (req_accept),
    .alloc_pc     (pc),
    .fill_en      (fill_en),
    .fill_data    (imem_rsp_data),
    .pop_en       (pop_en),
    .alloc_cnt    (alloc_cnt),
    .unfilled_cnt (unfilled_cnt),
    .head_valid   (head_valid),
    .head_pc      (head_pc),
    .head_instr   (head_instr)
  );

  // Fetch PC: redirect wins, otherwise step past each accepted request.
  always_ff @(posedge clk) begin
    if (rst)                 pc <= RESET_PC;
    else if (redirect_valid) pc <= redirect_pc;
    else if (req_accept)     pc <= pc + PC_STEP;
  end

  // Responses still owed for flushed slots; a response arriving in the
  // redirect cycle retires the oldest owed reply, whichever group it is in.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      if (outstanding != '0) drop_cnt <= outstanding - CW'(imem_rsp_valid);
      else                   drop_cnt <= '0;
    end else if (imem_rsp_valid && (drop_cnt != '0)) begin
      drop_cnt <= drop_cnt - CW'(1);
    end
  end

`ifndef SYNTHESIS
  // A response nobody is waiting for means the memory broke ordering.
  a_no_orphan_rsp : assert property (@(posedge clk) disable iff (rst)
    !(imem_rsp_valid && (drop_cnt == '0) && (unfilled_cnt == '0)))
    else $error("risc_pipe_fetch: response with no outstanding request");
`endif

endmodule
